// File: rtl/hex_display_pkg.sv
// Shared constants for the seven-segment display controller: modes, segment
// table and scroll FSM encoding.
package hex_display_pkg;

   localparam logic [1:0] MODE_STATIC = 2'b00;
   localparam logic [1:0] MODE_BLINK  = 2'b01;
   localparam logic [1:0] MODE_SCROLL = 2'b10;
   localparam logic [1:0] MODE_BLANK  = 2'b11;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
   localparam logic [6:0] SEG_TABLE [0:15] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {
      IDLE   = 1'b0,
      SCROLL = 1'b1
   } scroll_state_t;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller: static, blink, one-pass scroll and blank
// modes with leading-zero suppression and per-digit decimal points.
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS   = 6,
   parameter int TICK_DIV     = 5000000,
   parameter int BLINK_TICKS  = 5,
   parameter int SCROLL_TICKS = 3
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic [4*NUM_DIGITS-1:0]   load_data,
   input  logic [NUM_DIGITS-1:0]     load_dp,
   input  logic [1:0]                load_mode,
   input  logic                      lz_suppress,
   output logic                      busy,
   output logic [8*NUM_DIGITS-1:0]   seg_n
);

   localparam int PRE_W    = $clog2(TICK_DIV);
   localparam int BLINK_W  = $clog2(BLINK_TICKS + 1);
   localparam int SCROLL_W = $clog2(SCROLL_TICKS + 1);
   localparam int SHIFT_W  = $clog2(2*NUM_DIGITS + 1);

   logic [PRE_W-1:0]        pre_cnt;
   logic                    tick;
   logic                    accept;

   logic [4*NUM_DIGITS-1:0] data_p0;
   logic [NUM_DIGITS-1:0]   dp_p0;
   logic [1:0]              mode_p0;
   logic                    lz_p0;

   logic [BLINK_W-1:0]      blink_cnt;
   logic                    blink_hidden;

   scroll_state_t           state;
   logic [SCROLL_W-1:0]     scroll_cnt;
   logic [SHIFT_W-1:0]      shift_cnt;
   logic [7:0]              window [NUM_DIGITS];
   logic [7:0]              scroll_in;

   logic [6:0]              seg7        [NUM_DIGITS];
   logic [7:0]              src_byte    [NUM_DIGITS];
   logic [7:0]              static_byte [NUM_DIGITS];
   logic [8*NUM_DIGITS-1:0] seg_next;
   logic                    zero_run;

   assign tick   = (pre_cnt == PRE_W'(TICK_DIV - 1));
   assign accept = load_valid && load_ready;

   // Free-running base tick prescaler; loads do not disturb it
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pre_cnt <= '0;
      else if (tick)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + PRE_W'(1);
   end

   // Load stage: everything the display needs is captured on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_p0 <= '0;
         dp_p0   <= '0;
         mode_p0 <= MODE_STATIC;
         lz_p0   <= 1'b0;
      end else if (accept) begin
         data_p0 <= load_data;
         dp_p0   <= load_dp;
         mode_p0 <= load_mode;
         lz_p0   <= lz_suppress;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt    <= '0;
         blink_hidden <= 1'b0;
      end else if (accept) begin
         blink_cnt    <= '0;
         blink_hidden <= 1'b0;
      end else if (tick) begin
         if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
            blink_cnt    <= '0;
            blink_hidden <= ~blink_hidden;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_DIGITS; g++) begin : g_dec
         hex7seg u_dec (
            .nibble (data_p0[4*g +: 4]),
            .seg    (seg7[g])
         );
      end
   endgenerate

   // Blank a digit when it and all digits above it are zero; digit 0 always shows
   always_comb begin
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         src_byte[i] = {~dp_p0[i], seg7[i]};
         zero_run    = zero_run && (data_p0[4*i +: 4] == 4'h0);
         if (lz_p0 && zero_run && (i != 0))
            static_byte[i] = SEG_BLANK;
         else
            static_byte[i] = src_byte[i];
      end
   end

   // Source digits enter MS first; once all have entered, blanks follow
   always_comb begin
      scroll_in = SEG_BLANK;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (shift_cnt == SHIFT_W'(NUM_DIGITS - 1 - i))
            scroll_in = src_byte[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         load_ready <= 1'b1;
         scroll_cnt <= '0;
         shift_cnt  <= '0;
         for (int k = 0; k < NUM_DIGITS; k++)
            window[k] <= SEG_BLANK;
      end else begin
         case (state)
            IDLE: begin
               if (accept && (load_mode == MODE_SCROLL)) begin
                  state      <= SCROLL;
                  busy       <= 1'b1;
                  load_ready <= 1'b0;
                  scroll_cnt <= '0;
                  shift_cnt  <= '0;
                  for (int k = 0; k < NUM_DIGITS; k++)
                     window[k] <= SEG_BLANK;
               end
            end
            SCROLL: begin
               if (tick) begin
                  if (scroll_cnt == SCROLL_W'(SCROLL_TICKS - 1)) begin
                     scroll_cnt <= '0;
                     shift_cnt  <= shift_cnt + SHIFT_W'(1);
                     for (int k = NUM_DIGITS - 1; k > 0; k--)
                        window[k] <= window[k-1];
                     window[0] <= scroll_in;
                     if (shift_cnt == SHIFT_W'(2*NUM_DIGITS - 1)) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                     end
                  end else begin
                     scroll_cnt <= scroll_cnt + SCROLL_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      seg_next = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         case (mode_p0)
            MODE_STATIC: seg_next[8*i +: 8] = static_byte[i];
            MODE_BLINK:  seg_next[8*i +: 8] = blink_hidden ? SEG_BLANK : static_byte[i];
            MODE_SCROLL: seg_next[8*i +: 8] = (state == SCROLL) ? window[i] : SEG_BLANK;
            default:     seg_next[8*i +: 8] = SEG_BLANK;
         endcase
      end
   end

   // Output register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         seg_n <= '1;
      else
         seg_n <= seg_next;
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized and directed bench for hex_display_ctrl against a tick-count based model.
module tb_hex_display_ctrl;

   localparam int N  = 6;
   localparam int TD = 4;
   localparam int BT = 2;
   localparam int ST = 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           load_valid;
   logic           load_ready;
   logic [4*N-1:0] load_data;
   logic [N-1:0]   load_dp;
   logic [1:0]     load_mode;
   logic           lz_suppress;
   logic           busy;
   logic [8*N-1:0] seg_n;

   int total = 0;
   int bad   = 0;

   // Model state: everything is derived from ticks counted since the last load
   int             m_pre;
   int             m_ticks;
   logic [1:0]     m_mode;
   logic [4*N-1:0] m_data;
   logic [N-1:0]   m_dp;
   logic           m_lz;

   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   always #5 clk = ~clk;

   hex_display_ctrl #(
      .NUM_DIGITS   (N),
      .TICK_DIV     (TD),
      .BLINK_TICKS  (BT),
      .SCROLL_TICKS (ST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_data   (load_data),
      .load_dp     (load_dp),
      .load_mode   (load_mode),
      .lz_suppress (lz_suppress),
      .busy        (busy),
      .seg_n       (seg_n)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] digit_byte(input int d);
      return seg_tab[m_data[4*d +: 4]] & (m_dp[d] ? 8'h7F : 8'hFF);
   endfunction

   function automatic bit model_active();
      return (m_mode == 2'b10) && ((m_ticks / ST) < 2*N);
   endfunction

   function automatic logic [8*N-1:0] model_disp();
      logic [8*N-1:0] r;
      int msd, k, s;
      r = '1;
      if (m_mode == 2'b00 || (m_mode == 2'b01 && ((m_ticks / BT) % 2) == 0)) begin
         msd = 0;
         for (int i = 0; i < N; i++)
            if (m_data[4*i +: 4] != 4'h0) msd = i;
         for (int i = 0; i < N; i++)
            r[8*i +: 8] = (m_lz && i > msd) ? 8'hFF : digit_byte(i);
      end else if (m_mode == 2'b10) begin
         k = m_ticks / ST;
         if (k < 2*N)
            for (int j = 0; j < N; j++) begin
               s = k - j;
               if (s >= 1 && s <= N) r[8*j +: 8] = digit_byte(N - s);
            end
      end
      return r;
   endfunction

   task automatic model_reset();
      m_pre = 0; m_ticks = 0; m_mode = 2'b00; m_data = '0; m_dp = '0; m_lz = 1'b0;
   endtask

   task automatic step();
      logic [8*N-1:0] exp_seg;
      bit tk, acc;
      @(posedge clk);
      exp_seg = model_disp();
      tk  = (m_pre == TD - 1);
      acc = load_valid && !model_active();
      if (acc) begin
         m_data = load_data; m_dp = load_dp; m_mode = load_mode; m_lz = lz_suppress;
         m_ticks = 0;
      end else if (tk) begin
         m_ticks++;
      end
      m_pre = (m_pre + 1) % TD;
      #1;
      chk("seg_n", seg_n, exp_seg);
      chk("busy", busy, model_active());
      chk("load_ready", load_ready, !model_active());
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_seg", seg_n, {8*N{1'b1}});
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", load_ready, 1'b1);
      model_reset();
      #1 rst = 1'b0;
   endtask

   task automatic load(input logic [1:0] mode, input logic [4*N-1:0] d,
                       input logic [N-1:0] dp, input logic lz);
      load_valid = 1'b1; load_mode = mode; load_data = d; load_dp = dp; lz_suppress = lz;
      step();
      load_valid = 1'b0;
   endtask

   task automatic wait_ticks(input int t);
      int n = 0;
      while (m_ticks < t && n < 200) begin
         step();
         n++;
      end
      if (m_ticks < t) chk("wait_ticks", m_ticks, t);
   endtask

   initial begin
      rst = 1'b1; load_valid = 1'b0; load_data = '0; load_dp = '0;
      load_mode = 2'b00; lz_suppress = 1'b0;
      model_reset();
      #3;
      chk("init_seg", seg_n, {8*N{1'b1}});
      chk("init_busy", busy, 1'b0);
      chk("init_ready", load_ready, 1'b1);
      #5 rst = 1'b0;
      repeat (3) step();

      load(2'b00, 24'h0123AF, 6'b000001, 1'b0);
      step();
      chk("static", seg_n, 48'hC0F9A4B0880E);
      load(2'b00, 24'h0123AF, 6'b000001, 1'b1);
      step();
      chk("static_lz", seg_n, 48'hFFF9A4B0880E);
      load(2'b00, 24'h000000, 6'b000000, 1'b1);
      step();
      chk("zero_lz", seg_n, 48'hFFFFFFFFFFC0);

      load(2'b01, 24'h111111, 6'b000000, 1'b0);
      step();
      chk("blink_vis", seg_n, 48'hF9F9F9F9F9F9);
      repeat (10) step();
      load(2'b01, 24'h111111, 6'b000000, 1'b0);
      step();
      chk("blink_reload", seg_n, 48'hF9F9F9F9F9F9);
      repeat (20) step();

      load(2'b11, 24'h123456, 6'b111111, 1'b0);
      repeat (3) step();
      chk("blank", seg_n, {8*N{1'b1}});

      load(2'b10, 24'h123456, 6'b000000, 1'b0);
      chk("scroll_busy", busy, 1'b1);
      wait_ticks(3);
      load_valid = 1'b1; load_mode = 2'b00; load_data = 24'hABCDEF;
      step();
      load_valid = 1'b0;
      wait_ticks(6);
      step();
      chk("scroll_full", seg_n, 48'hF9A4B0999282);
      wait_ticks(12);
      step();
      chk("scroll_end_seg", seg_n, {8*N{1'b1}});
      chk("scroll_end_busy", busy, 1'b0);

      load(2'b10, 24'h123456, 6'b000100, 1'b0);
      wait_ticks(4);
      do_reset();
      load(2'b00, 24'hFFFFFF, 6'b000000, 1'b0);
      step();
      chk("after_rst", seg_n, 48'h8E8E8E8E8E8E);

      for (int c = 0; c < 1500; c++) begin
         load_valid  = ($urandom_range(0, 15) == 0);
         load_mode   = 2'($urandom_range(0, 3));
         load_data   = 24'($urandom) >> (4 * $urandom_range(0, 6));
         load_dp     = 6'($urandom);
         lz_suppress = 1'($urandom);
         step();
         if ($urandom_range(0, 499) == 0) do_reset();
      end
      load_valid = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
